icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/icache_refill.sv | 143 ++++++++++++++
 tb/tb_icache_refill.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine.
// On a miss request, issues one AXI INCR read burst for the whole line,
// assembles the returned beats into a line buffer, and pulses rvalid
// for one cycle once the beat carrying rlast has been stored.
module icache_refill #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // cache side
    input  logic                     req,
    input  logic [31:0]              addr,
    output logic                     rvalid,
    output logic [LINE_WORDS*32-1:0] rdata,
    output logic                     err,
    output logic                     busy,

    // AXI read-address channel
    output logic [3:0]               arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,

    // AXI read-data channel
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata_axi,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid_axi,
    output logic                     rready
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    // Clears the byte offset within a line.
    localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [31:0]         addr_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic                err_reg;
    logic [31:0]         line_reg [LINE_WORDS];

    logic                start;
    logic                beat_accept;
    logic                beat_own;

    // A new refill is only ever sampled in IDLE; anything on req/addr
    // while busy is ignored.
    assign start       = (state_reg == IDLE) && req;
    // Every beat presented during DATA is acknowledged; only beats with
    // our ID touch the line, the counter or the error flag.
    assign beat_accept = (state_reg == DATA) && rvalid_axi;
    assign beat_own    = beat_accept && (rid == AXI_ID);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; completion is keyed on rlast of an own-ID beat,
    // never on the beat counter.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (req)               state_next = ADDR;
            ADDR: if (arready)           state_next = DATA;
            DATA: if (beat_own && rlast) state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Request address, beat counter and sticky error for the current line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg <= 32'd0;
            beat_reg <= '0;
            err_reg  <= 1'b0;
        end else if (start) begin
            addr_reg <= addr & ALIGN_MASK;
            beat_reg <= '0;
            err_reg  <= 1'b0;
        end else if (beat_own) begin
            // A burst longer than the line wraps and overwrites word 0.
            beat_reg <= beat_reg + BEAT_W'(1);
            err_reg  <= err_reg | (rresp != 2'b00);
        end
    end

    // Line buffer: one register per word, written when the counter
    // points at it. Contents persist from DONE until overwritten by the
    // next refill's beats.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            // Capture the beat addressed to this word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_reg[gi] <= 32'd0;
                end else if (beat_own && (beat_reg == BEAT_W'(gi))) begin
                    line_reg[gi] <= rdata_axi;
                end
            end
            assign rdata[gi*32 +: 32] = line_reg[gi];
        end
    endgenerate

    // AXI request fields are constant apart from the address, which is
    // held in addr_reg for the whole refill so it stays stable under
    // arready backpressure.
    assign arid    = AXI_ID;
    assign araddr  = addr_reg;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = (state_reg == ADDR);
    assign rready  = (state_reg == DATA);

    assign rvalid  = (state_reg == DONE);
    assign err     = err_reg;
    assign busy    = (state_reg != IDLE);

    // Address bits below the line offset are intentionally dropped.
    localparam int UNUSED_OFF = OFF_W;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: an AXI slave model driven from one
// initial block, with expected lines queued on request and compared when
// the refill engine pulses rvalid.
module tb_icache_refill;

    localparam int LW = 8;
    typedef logic [LW*32-1:0] line_t;

    typedef struct {
        line_t       line;
        logic        err;
        logic [31:0] araddr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic [31:0]       addr;
    logic              rvalid;
    line_t             line_data;
    logic              err;
    logic              busy;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata_axi;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid_axi;
    logic              rready;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];

    icache_refill #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .addr       (addr),
        .rvalid     (rvalid),
        .rdata      (line_data),
        .err        (err),
        .busy       (busy),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rid        (rid),
        .rdata_axi  (rdata_axi),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid_axi (rvalid_axi),
        .rready     (rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input line_t obs, input line_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one read-data beat at a falling edge; it is taken on the
    // following rising edge.
    task automatic drive_beat(input logic [3:0] id, input logic [31:0] d,
                              input logic [1:0] resp, input logic last);
        rvalid_axi = 1'b1;
        rid        = id;
        rdata_axi  = d;
        rresp      = resp;
        rlast      = last;
        check("rready_in_data", line_t'(rready), line_t'(1'b1));
        check("ar_quiet_in_data", line_t'(arvalid), line_t'(1'b0));
        @(negedge clk);
        rvalid_axi = 1'b0;
        rlast      = 1'b0;
    endtask

    // Wait for the address phase, bounded; returns 1 if arvalid was seen.
    task automatic wait_ar(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arvalid) begin
                found = 1'b1;
                break;
            end
        end
        check("ar_seen", line_t'(found), line_t'(1'b1));
    endtask

    task automatic run_refill(input logic [31:0] a, input int ar_wait,
                              input bit gapped, input int err_beat,
                              input int foreign_after, input bit addr_change,
                              input logic [31:0] base, input bit chk_lat);
        exp_t e;
        exp_t got;
        int   t0;
        bit   found;
        e.araddr = a & ~(32'(LW * 4) - 32'd1);
        e.err    = (err_beat >= 0);
        for (int i = 0; i < LW; i++) e.line[i*32 +: 32] = base + 32'(i);
        sb.push_back(e);

        req  = 1'b1;
        addr = a;
        t0   = cyc;
        wait_ar(found);
        if (!found) begin
            req = 1'b0;
            void'(sb.pop_back());
            return;
        end
        check("araddr", line_t'(araddr), line_t'(e.araddr));
        check("arlen", line_t'(arlen), line_t'(8'(LW - 1)));
        check("arsize_arburst_arid", line_t'({arsize, arburst, arid}),
              line_t'({3'b010, 2'b01, 4'd0}));
        for (int i = 0; i < ar_wait; i++) begin
            arready = 1'b0;
            @(negedge clk);
            check("ar_hold_valid", line_t'(arvalid), line_t'(1'b1));
            check("ar_hold_addr", line_t'({araddr, arlen}), line_t'({e.araddr, 8'(LW - 1)}));
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("ar_drop", line_t'(arvalid), line_t'(1'b0));

        for (int b = 0; b < LW; b++) begin
            drive_beat(4'd0, base + 32'(b), (b == err_beat) ? 2'b10 : 2'b00, b == LW - 1);
            if (b == 0 && addr_change) addr = 32'h0000_1000;
            if (b == foreign_after) drive_beat(4'd5, 32'hDEAD_BEEF, 2'b00, 1'b0);
            if (gapped && b != LW - 1) begin
                @(negedge clk);
                check("no_early_rvalid", line_t'(rvalid), line_t'(1'b0));
            end
        end

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rvalid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rvalid_seen", line_t'(found), line_t'(1'b1));
        if (!found) begin
            req = 1'b0;
            void'(sb.pop_back());
            return;
        end
        req = 1'b0;
        got = sb.pop_front();
        if (chk_lat) begin
            check("latency", line_t'(cyc - t0), line_t'(LW + 2));
            check("word0", line_t'(line_data[31:0]), line_t'(base));
            check("word_last", line_t'(line_data[LW*32-1 -: 32]), line_t'(base + 32'(LW - 1)));
        end
        check("line", line_data, got.line);
        check("err", line_t'(err), line_t'(got.err));
        check("araddr_kept", line_t'(araddr), line_t'(got.araddr));
        $display("refill addr=%08h araddr=%08h err=%0b line0=%08h", a, araddr, err, line_data[31:0]);
        @(negedge clk);
        check("rvalid_one_cycle", line_t'(rvalid), line_t'(1'b0));
        check("idle_after_done", line_t'({busy, arvalid}), line_t'(2'b00));
        check("line_stable", line_data, got.line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n      = 1'b0;
        req        = 1'b0;
        addr       = 32'd0;
        arready    = 1'b0;
        rid        = 4'd0;
        rdata_axi  = 32'd0;
        rresp      = 2'b00;
        rlast      = 1'b0;
        rvalid_axi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", line_t'({busy, arvalid, rready, rvalid, err}), line_t'(5'b0));
        check("reset_line", line_data, line_t'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", line_t'(busy), line_t'(1'b0));

        // zero-wait refill with latency
        run_refill(32'h1FC0_0014, 0, 1'b0, -1, -1, 1'b0, 32'h100, 1'b1);
        // arready backpressure and gapped data
        run_refill(32'h0000_4A2C, 3, 1'b1, -1, -1, 1'b0, 32'h2000, 1'b0);
        // error on beat 3, then a clean line clears err
        run_refill(32'h8000_0104, 0, 1'b0, 3, -1, 1'b0, 32'h300, 1'b0);
        run_refill(32'h8000_0124, 0, 1'b0, -1, -1, 1'b0, 32'h400, 1'b0);

        // reset in the middle of a burst
        req  = 1'b1;
        addr = 32'h2000_0040;
        wait_ar(found);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 5; b++) drive_beat(4'd0, 32'h900 + 32'(b), 2'b00, 1'b0);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        check("midreset_ctrl", line_t'({busy, arvalid, rready, rvalid, err}), line_t'(5'b0));
        check("midreset_line", line_data, line_t'(0));
        $display("reset mid-burst busy=%0b rready=%0b", busy, rready);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 5; b < LW; b++) begin
            rvalid_axi = 1'b1;
            rdata_axi  = 32'h900 + 32'(b);
            rlast      = (b == LW - 1);
            check("stray_not_acked", line_t'({rready, rvalid}), line_t'(2'b00));
            @(negedge clk);
        end
        rvalid_axi = 1'b0;
        rlast      = 1'b0;
        check("stray_still_idle", line_t'({busy, rvalid}), line_t'(2'b00));

        // normal refill after reset
        run_refill(32'h0400_0000, 0, 1'b0, -1, -1, 1'b0, 32'h500, 1'b1);
        // addr change while busy is ignored
        run_refill(32'h3000_0080, 0, 1'b0, -1, -1, 1'b1, 32'h600, 1'b0);
        // foreign rid beat interleaved after beat 2
        run_refill(32'h0000_01E0, 1, 1'b0, -1, 2, 1'b0, 32'h700, 1'b0);

        check("scoreboard_empty", line_t'(sb.size()), line_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
